blend_mult_scheduler: RTL and testbench

Sequences a single shared approximate 8x8 multiplier (`multiplier2`, connected externally) to blend two image streams pixel by pixel. For each accepted pixel pair, the block computes `y = hi(p1*w1) + hi(p2*w2)`, where `hi()` is bits [15:8] of the 16-bit product. It sits between the pixel source (two RGB byte streams) and the output image buffer. It replaces the two parallel multiplier instances with one time-multiplexed instance and adds valid/ready flow control and frame counting.

---
 rtl/blend_mult_scheduler.sv | 122 ++++++++++++
 tb/tb_blend_mult_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blend_mult_scheduler.sv
// Time-multiplexes one shared 8x8 multiplier to blend two pixel streams:
// y = hi(p1*w1) + hi(p2*w2), with valid/ready handshakes and frame counting.
module blend_mult_scheduler #(
  parameter int NPIX     = 270000,
  parameter bit SATURATE = 1'b0,
  localparam int CW      = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    p1,
  input  logic [7:0]    p2,
  input  logic [7:0]    w1,
  input  logic [7:0]    w2,
  output logic [7:0]    mul_a,
  output logic [7:0]    mul_b,
  input  logic [15:0]   mul_y,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [7:0]    y,
  output logic [CW-1:0] pix_cnt,
  output logic          frame_done
);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, OUT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    p2_q, p2_d, w2_q, w2_d, r1_q, r1_d;
  logic [7:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d, y_q, y_d;
  logic          m_valid_q, m_valid_d, frame_done_q, frame_done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    sum;
  logic          mul_lo_unused;

  // Only the high byte of each product contributes to the blend.
  assign mul_lo_unused = ^mul_y[7:0];

  always_comb begin
    state_d      = state_q;
    p2_d         = p2_q;
    w2_d         = w2_q;
    r1_d         = r1_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    y_d          = y_q;
    m_valid_d    = m_valid_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    sum          = {1'b0, r1_q} + {1'b0, mul_y[15:8]};
    unique case (state_q)
      IDLE: begin
        if (s_valid) begin
          p2_d    = p2;
          w2_d    = w2;
          mul_a_d = p1;
          mul_b_d = w1;
          state_d = MUL1;
        end
      end
      MUL1: begin
        r1_d    = mul_y[15:8];
        mul_a_d = p2_q;
        mul_b_d = w2_q;
        state_d = MUL2;
      end
      MUL2: begin
        y_d       = (SATURATE && sum[8]) ? 8'hFF : sum[7:0];
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
          if (cnt_q == CW'(NPIX - 1)) begin
            cnt_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      p2_q         <= '0;
      w2_q         <= '0;
      r1_q         <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      y_q          <= '0;
      m_valid_q    <= 1'b0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p2_q         <= p2_d;
      w2_q         <= w2_d;
      r1_q         <= r1_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      y_q          <= y_d;
      m_valid_q    <= m_valid_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_ready    = (state_q == IDLE) && !rst;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign m_valid    = m_valid_q;
  assign y          = y_q;
  assign pix_cnt    = cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_blend_mult_scheduler.sv
// Bench for blend_mult_scheduler: wrap and saturate instances fed the same stream,
// exact-product multiplier models, scoreboard-checked outputs and frame counter.
module tb_blend_mult_scheduler;

  localparam int NP = 4;

  typedef struct packed {
    logic [7:0] p1, p2, w1, w2, e0, e1;
  } vec_t;

  logic        clk, rst, s_valid, m_ready, m_ready_man, rnd_mode, rnd_bit, mon_en;
  logic [7:0]  p1, p2, w1, w2;
  logic        s_ready0, s_ready1, m_valid0, m_valid1, fd0, fd1;
  logic [7:0]  mul_a0, mul_b0, mul_a1, mul_b1, y0, y1;
  logic [15:0] mul_y0, mul_y1;
  logic [1:0]  cnt0, cnt1;
  int          n_checks, n_errors, cyc, acc_cyc;
  int          exp_cnt;
  bit          exp_fd;
  vec_t        sb[$];
  vec_t        vecs[8];

  blend_mult_scheduler #(.NPIX(NP), .SATURATE(1'b0)) u0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0),
    .p1(p1), .p2(p2), .w1(w1), .w2(w2),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_y(mul_y0),
    .m_valid(m_valid0), .m_ready(m_ready), .y(y0),
    .pix_cnt(cnt0), .frame_done(fd0));

  blend_mult_scheduler #(.NPIX(NP), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1),
    .p1(p1), .p2(p2), .w1(w1), .w2(w2),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_y(mul_y1),
    .m_valid(m_valid1), .m_ready(m_ready), .y(y1),
    .pix_cnt(cnt1), .frame_done(fd1));

  assign mul_y0  = {8'd0, mul_a0} * {8'd0, mul_b0};
  assign mul_y1  = {8'd0, mul_a1} * {8'd0, mul_b1};
  assign m_ready = rnd_mode ? rnd_bit : m_ready_man;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] blend(input logic [7:0] a, b, c, d, input bit sat);
    logic [15:0] x1, x2;
    logic [8:0]  s;
    x1 = {8'd0, a} * {8'd0, c};
    x2 = {8'd0, b} * {8'd0, d};
    s  = {1'b0, x1[15:8]} + {1'b0, x2[15:8]};
    return (sat && s[8]) ? 8'hFF : s[7:0];
  endfunction

  function automatic vec_t mk(input logic [7:0] a, b, c, d);
    return '{a, b, c, d, blend(a, b, c, d, 1'b0), blend(a, b, c, d, 1'b1)};
  endfunction

  // Output scoreboard plus a per-cycle model of pix_cnt / frame_done.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pix_cnt_wrap", 32'(cnt0), 32'(exp_cnt));
      chk("pix_cnt_sat", 32'(cnt1), 32'(exp_cnt));
      chk("frame_done_wrap", 32'(fd0), 32'(exp_fd));
      chk("frame_done_sat", 32'(fd1), 32'(exp_fd));
      chk("m_valid_pair", 32'(m_valid1), 32'(m_valid0));
      if (rst) begin
        chk("s_ready_in_rst", 32'(s_ready0), 0);
        exp_cnt = 0;
        exp_fd  = 1'b0;
      end else if (m_valid0 && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          vec_t e;
          e = sb.pop_front();
          $display("out p1=%02h p2=%02h w1=%02h w2=%02h y_wrap=%02h y_sat=%02h",
                   e.p1, e.p2, e.w1, e.w2, y0, y1);
          chk("y_wrap", 32'(y0), 32'(e.e0));
          chk("y_sat", 32'(y1), 32'(e.e1));
        end
        exp_fd  = (exp_cnt == NP - 1);
        exp_cnt = exp_fd ? 0 : exp_cnt + 1;
      end else begin
        exp_fd = 1'b0;
      end
    end
  end

  // Returns #1 after the accepting edge (DUT in MUL1); acc_cyc records that edge.
  task automatic send(input vec_t v);
    p1 = v.p1; p2 = v.p2; w1 = v.w1; w2 = v.w2;
    s_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s_ready0) break;
    end
    if (!s_ready0) begin
      chk("accept_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    s_valid = 1'b0;
    p1 = 8'($urandom); p2 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
  endtask

  task automatic drain(input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("drain_timeout", 32'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vb;
    int   prev, y_hold;
    vecs[0] = '{8'h80, 8'h40, 8'h80, 8'h80, 8'h60, 8'h60};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'hFF};
    vecs[2] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFE, 8'hFE};
    vecs[4] = '{8'h10, 8'h20, 8'h10, 8'h20, 8'h05, 8'h05};
    vecs[5] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h20, 8'hFF};
    vecs[6] = '{8'h01, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00};
    vecs[7] = '{8'h80, 8'h80, 8'hFF, 8'hFF, 8'hFE, 8'hFE};
    n_checks = 0; n_errors = 0; cyc = 0; acc_cyc = 0;
    exp_cnt = 0; exp_fd = 1'b0; mon_en = 1'b0;
    rst = 1'b1; s_valid = 1'b0; m_ready_man = 1'b1; rnd_mode = 1'b0;
    p1 = 8'h00; p2 = 8'h00; w1 = 8'h00; w2 = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready0), 0);
    chk("rst_mul_a", 32'(mul_a0), 0);
    chk("rst_mul_b", 32'(mul_b0), 0);
    chk("rst_y", 32'(y0), 0);
    chk("rst_m_valid", 32'(m_valid0), 0);
    chk("rst_pix_cnt", 32'(cnt0), 0);
    chk("rst_frame_done", 32'(fd0), 0);
    rst = 1'b0;
    #1;
    chk("idle_s_ready", 32'(s_ready0), 1);
    mon_en = 1'b1;

    // Basic blend with cycle-exact operand sequencing and 3-cycle latency.
    send(vecs[0]);
    chk("t1_mul_a", 32'(mul_a0), 32'h80);
    chk("t1_mul_b", 32'(mul_b0), 32'h80);
    chk("t1_m_valid", 32'(m_valid0), 0);
    chk("t1_s_ready", 32'(s_ready0), 0);
    @(posedge clk); #1;
    chk("t2_mul_a", 32'(mul_a0), 32'h40);
    chk("t2_mul_b", 32'(mul_b0), 32'h80);
    chk("t2_m_valid", 32'(m_valid0), 0);
    @(posedge clk); #1;
    chk("t3_m_valid", 32'(m_valid0), 1);
    chk("t3_y", 32'(y0), 32'h60);
    @(posedge clk); #1;
    chk("t4_m_valid", 32'(m_valid0), 0);
    chk("t4_s_ready", 32'(s_ready0), 1);
    chk("t4_mul_a_hold", 32'(mul_a0), 32'h40);

    // Table vectors back to back: spacing must be exactly 4 cycles.
    for (int i = 0; i < 8; i++) begin
      prev = acc_cyc;
      send(vecs[i]);
      if (i > 0) chk("throughput", 32'(acc_cyc - prev), 4);
    end
    drain(50);

    // Backpressure: output held, second pair waits for the cycle after m_ready.
    m_ready_man = 1'b0;
    send(mk(8'h12, 8'h34, 8'h56, 8'h78));
    vb = mk(8'hA5, 8'h5A, 8'hC3, 8'h3C);
    p1 = vb.p1; p2 = vb.p2; w1 = vb.w1; w2 = vb.w2;
    s_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_valid0) break;
    end
    chk("bp_m_valid_seen", 32'(m_valid0), 1);
    y_hold = 32'(y0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_m_valid_hold", 32'(m_valid0), 1);
      chk("bp_y_hold", 32'(y0), 32'(y_hold));
      chk("bp_s_ready", 32'(s_ready0), 0);
    end
    @(posedge clk); #1;
    m_ready_man = 1'b1;
    @(negedge clk);
    chk("bp_s_ready_pending", 32'(s_ready0), 0);
    sb.push_back(vb);
    @(posedge clk); #1;
    chk("bp_idle_s_ready", 32'(s_ready0), 1);
    chk("bp_m_valid_clear", 32'(m_valid0), 0);
    @(posedge clk); #1;
    chk("bp_accepted", 32'(s_ready0), 0);
    chk("bp_mul_a", 32'(mul_a0), 32'(vb.p1));
    s_valid = 1'b0;
    drain(50);

    // Reset in MUL2: pixel discarded, everything back to reset values.
    send(mk(8'h77, 8'h99, 8'hEE, 8'h11));
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mr_s_ready", 32'(s_ready0), 0);
    @(posedge clk); #1;
    chk("mr_m_valid", 32'(m_valid0), 0);
    chk("mr_y_wrap", 32'(y0), 0);
    chk("mr_y_sat", 32'(y1), 0);
    chk("mr_mul_a", 32'(mul_a0), 0);
    chk("mr_mul_b", 32'(mul_b0), 0);
    chk("mr_pix_cnt", 32'(cnt0), 0);
    chk("mr_frame_done", 32'(fd0), 0);
    rst = 1'b0;
    send(mk(8'h40, 8'hC0, 8'h80, 8'hFF));
    drain(50);

    // Random pairs with random downstream stalls.
    rnd_mode = 1'b1;
    for (int i = 0; i < 24; i++)
      send(mk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)));
    drain(600);
    rnd_mode = 1'b0;
    repeat (3) @(posedge clk);
    chk("final_queue_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
